// File: rtl/data_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : data_mem_pkg                                                   |
// | Description : Shared types and boot constants for data_mem_bytewise.       |
// |               FSM state enum, boot-table size and a helper that classifies  |
// |               each boot word so it can be widened to any DATA_W.           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package data_mem_pkg;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam int BOOT_WORDS = 8;

   // Boot words are sign-extended patterns, so only their kind is stored here;
   // the consumer expands the kind to its own data width.
   typedef enum logic [1:0] {
      BOOT_ZERO    = 2'd0,
      BOOT_ONES    = 2'd1,
      BOOT_ONES_M1 = 2'd2
   } boot_kind_e;

   function automatic boot_kind_e boot_kind(input int unsigned addr);
      boot_kind_e k;
      k = BOOT_ZERO;
      if (addr < 3)
         k = BOOT_ONES_M1;
      else if (addr >= 4 && addr < 7)
         k = BOOT_ONES;
      return k;
   endfunction

endpackage : data_mem_pkg
`default_nettype wire

// File: rtl/data_mem_bytewise_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : data_mem_bytewise_if                                          |
// | Description : Request/response bus of the data memory.                     |
// |   master : drives req_valid/req_we/req_addr/req_wdata/req_be               |
// |            receives req_ready/rsp_valid/rsp_rdata/init_done                 |
// |   slave  : the memory side (mirror of master)                              |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface data_mem_bytewise_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_W-1:0]     req_addr;
   logic [DATA_W-1:0]     req_wdata;
   logic [DATA_W/8-1:0]   req_be;
   logic                  rsp_valid;
   logic [DATA_W-1:0]     rsp_rdata;
   logic                  init_done;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be,
      input  req_ready, rsp_valid, rsp_rdata, init_done
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be,
      output req_ready, rsp_valid, rsp_rdata, init_done
   );
endinterface : data_mem_bytewise_if
`default_nettype wire

// File: rtl/data_mem_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : data_mem_ram                                                  |
// | Description : Single-port storage array, byte-enabled write, registered    |
// |               read.                                                        |
// |   clk, rst     : clock / synchronous reset (read register only)            |
// |   we, be       : write strobe and per-byte enables                         |
// |   addr         : shared word address                                       |
// |   wdata        : write data                                                |
// |   re, rzero    : read strobe; rzero forces the registered result to 0      |
// |   rdata        : registered read data                                      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module data_mem_ram #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  wire logic                clk,
   input  wire logic                rst,
   input  wire logic                we,
   input  wire logic [DATA_W/8-1:0] be,
   input  wire logic [ADDR_W-1:0]   addr,
   input  wire logic [DATA_W-1:0]   wdata,
   input  wire logic                re,
   input  wire logic                rzero,
   output      logic [DATA_W-1:0]   rdata
);
   localparam int c_nbytes = DATA_W / 8;

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Storage carries no reset; contents are established by the init sweep.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < c_nbytes; i++) begin
            if (be[i])
               r_mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
   end

   // Out-of-range reads are flagged by the caller and return zero instead of
   // indexing past the array.
   always_ff @(posedge clk) begin
      if (rst)
         rdata <= '0;
      else if (re)
         rdata <= rzero ? '0 : r_mem[addr];
   end
endmodule : data_mem_ram
`default_nettype wire

// File: rtl/data_mem_bytewise.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : data_mem_bytewise                                             |
// | Description : Parametrised data memory for the MEM stage. After reset an   |
// |               INIT sweep writes every word (boot constants when            |
// |               DATA_MEM_PRELOAD_EN is defined, otherwise zero), then the    |
// |               RUN state accepts one request per cycle with no backpressure.|
// |   clk, rst : clock / synchronous active-high reset                         |
// |   bus      : data_mem_bytewise_if.slave (request, response, init_done)     |
// | Config   : `define DATA_MEM_PRELOAD_EN to sweep boot constants into 0..7   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module data_mem_bytewise
   import data_mem_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input wire logic           clk,
   input wire logic           rst,
   data_mem_bytewise_if.slave bus
);
   // One extra pointer bit keeps the sweep counter from wrapping at DEPTH.
   localparam int                c_ptr_w    = $clog2(DEPTH) + 1;
   localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(DEPTH - 1);
   localparam logic [ADDR_W:0]    c_depth    = (ADDR_W + 1)'(DEPTH);

   state_e                r_state;
   logic [c_ptr_w-1:0]    r_init_ptr;
   logic                  r_req_ready;
   logic                  r_rsp_valid;
   logic                  r_init_done;

   logic                  w_accept;
   logic                  w_in_range;
   logic                  w_init_we;
   logic                  w_ram_we;
   logic                  w_ram_re;
   logic [ADDR_W-1:0]     w_ram_addr;
   logic [DATA_W-1:0]     w_ram_wdata;
   logic [DATA_W/8-1:0]   w_ram_be;
   logic [DATA_W-1:0]     w_boot;
   logic [DATA_W-1:0]     w_rdata;

   assign w_accept   = bus.req_valid & r_req_ready;
   assign w_in_range = {1'b0, bus.req_addr} < c_depth;
   assign w_init_we  = (r_state == ST_INIT) & ~rst;

`ifdef DATA_MEM_PRELOAD_EN
   always_comb begin
      w_boot = '0;
      case (boot_kind(32'(r_init_ptr)))
         BOOT_ONES:    w_boot = '1;
         BOOT_ONES_M1: w_boot = {{(DATA_W-1){1'b1}}, 1'b0};
         default:      w_boot = '0;
      endcase
   end
`else
   assign w_boot = '0;
`endif

   // The sweep owns the single port during INIT; requests own it in RUN.
   // Nothing is written on a reset edge.
   always_comb begin
      w_ram_we    = 1'b0;
      w_ram_re    = 1'b0;
      w_ram_addr  = bus.req_addr;
      w_ram_wdata = bus.req_wdata;
      w_ram_be    = bus.req_be;
      if (w_init_we) begin
         w_ram_we    = 1'b1;
         w_ram_addr  = ADDR_W'(r_init_ptr);
         w_ram_wdata = w_boot;
         w_ram_be    = '1;
      end else if (w_accept && !rst) begin
         w_ram_we = bus.req_we & w_in_range;
         w_ram_re = ~bus.req_we;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_INIT;
         r_init_ptr  <= '0;
         r_req_ready <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_init_done <= 1'b0;
      end else begin
         case (r_state)
            ST_INIT: begin
               r_rsp_valid <= 1'b0;
               r_init_ptr  <= r_init_ptr + 1'b1;
               if (r_init_ptr == c_last_ptr) begin
                  r_state     <= ST_RUN;
                  r_req_ready <= 1'b1;
                  r_init_done <= 1'b1;
               end
            end
            ST_RUN: begin
               r_rsp_valid <= w_accept & ~bus.req_we;
            end
            default: begin
               r_state <= ST_INIT;
            end
         endcase
      end
   end

   data_mem_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (w_ram_we),
      .be    (w_ram_be),
      .addr  (w_ram_addr),
      .wdata (w_ram_wdata),
      .re    (w_ram_re),
      .rzero (~w_in_range),
      .rdata (w_rdata)
   );

   assign bus.req_ready = r_req_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_rdata = w_rdata;
   assign bus.init_done = r_init_done;
endmodule : data_mem_bytewise
`default_nettype wire
